lms_coeff_update: RTL and testbench
===================================

# lms_coeff_update

- Serial LMS coefficient engine that produces the coefficient vector consumed by the direct-form FIR.
- Each pass applies w[k] <= sat(w[k] + mu·e·x[k]) for all taps, where x is a snapshot of the FIR tap vector and e is the error sample.
- One shared multiplier datapath is time-multiplexed over the taps.
- Results go into a shadow bank and are committed atomically, so the FIR never sees a half-updated vector.

## Interface

Parameters:
- WIDTH, 16, sample/coefficient word width, two's complement.
- FRAC, 14, fractional bits (Q(WIDTH-FRAC).FRAC).
- TAPS, 8, number of coefficients; must be ≥ 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  request one update pass; sampled only in IDLE.
- i_clear  in  1  zero all coefficients; sampled only in IDLE.
- i_x  in  [TAPS-1:0][WIDTH-1:0]  input tap snapshot; x[0] is the newest sample.
- i_err  in  WIDTH  error sample e = desired − FIR output.
- i_mu  in  WIDTH  step size, same Q format.
- o_coeffs  out  [TAPS-1:0][WIDTH-1:0]  committed coefficients; drives FIR i_coeffs.
- o_busy  out  1  high while state ≠ IDLE.
- o_done  out  1  one-cycle pulse in the first cycle new o_coeffs are visible.
- o_ovr  out  1  sticky saturation flag for the most recent pass.

## Operation

- States: IDLE → SCALE → UPDATE → COMMIT → IDLE.
- IDLE:
  - i_clear=1: shadow and o_coeffs are zeroed, o_ovr is cleared, and i_start in the same cycle is dropped (clear has priority).
  - else i_start=1: latch i_x, i_err and i_mu into internal registers, clear o_ovr, go to SCALE.
- SCALE: step <= sat(mu·e); go to UPDATE with k=0.
- UPDATE: shadow[k] <= sat(shadow[k] + sat(step·x[k])); k++. After k=TAPS-1, go to COMMIT.
- COMMIT: o_coeffs <= shadow; o_done <= 1; go to IDLE.
- Arithmetic:
  - Full-precision product, arithmetic right shift by FRAC (truncate toward −∞).
  - Every product and the sum saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - Any saturation sets o_ovr, which holds until the next accepted start or clear.
- Inputs are used only through the latched copies, so i_x, i_err and i_mu may change freely once a pass is accepted.
- i_start and i_clear are ignored while busy; there is no queueing.
- o_coeffs holds its value during SCALE and UPDATE.

## Timing

- Reset values: o_coeffs=0, shadow=0, o_busy=0, o_done=0, o_ovr=0, state=IDLE, k=0.
- Start accepted at edge E0.
- The step register is written at E1.
- Taps are written at E2 … E(TAPS+1).
- Commit happens at E(TAPS+2). o_done=1 and o_busy=0 in the cycle following it. Total latency is TAPS+2 cycles.
- o_busy is high from after E0 through the cycle before o_done.
- Back-to-back passes: i_start asserted in the o_done cycle is accepted (state is IDLE). Throughput is one pass per TAPS+3 cycles.
- Reset mid-pass aborts: all state is zeroed and no o_done pulse is produced.
- o_done never asserts twice for one accepted start.

## Structure

- Package lms_pkg holds the state_t enum (IDLE, SCALE, UPDATE, COMMIT) and a sat_trunc function used for product narrowing.
- Reuse the existing fmult for both the step product and the tap product (one instance, operand-muxed by state).
- One new sub-module, fsat_add: WIDTH-wide saturating adder with an o_ovr output.
- The tap index counter is clog2(TAPS) bits wide.

## Test plan

All scenarios use WIDTH=16, FRAC=14, TAPS=4; 1.0 = 16384.

- Reset, then idle 10 cycles → o_coeffs={0,0,0,0}, o_busy=0, o_done=0, o_ovr=0.
- mu=8192, err=8192, x={4096,−4096,8192,0}, start → o_done exactly 6 cycles after the start edge; o_coeffs={1024,−1024,2048,0}; o_ovr=0; o_coeffs unchanged while busy.
- Repeat the same pass with start asserted in the o_done cycle → accepted; o_coeffs={2048,−2048,4096,0}.
- Saturation: clear, then two passes with mu=32767, err=16384, x={16384,0,0,0}:
  - after the first pass, w0=32767 and o_ovr=0;
  - after the second pass, w0=32767 and o_ovr=1;
  - the next start clears o_ovr.
- Pulse i_start mid-pass → ignored, exactly one o_done. Assert i_clear and i_start together in IDLE → coefficients zero and no pass runs.
- Assert i_rst in the second UPDATE cycle → all outputs 0 the next cycle, no o_done. A following start completes normally.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared types and fixed-point helpers for the LMS coefficient engine.
package lms_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALE  = 2'd1,
    UPDATE = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Narrow a full-precision product: arithmetic shift right by frac (floor),
  // then clamp to the signed range of a width-bit word. Operates on a 64-bit
  // container so one function serves any WIDTH up to 32.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] prod,
                                                   input int frac,
                                                   input int width);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = prod >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (sh > hi) begin
      return hi;
    end else if (sh < lo) begin
      return lo;
    end else begin
      return sh;
    end
  endfunction

endpackage

// File: rtl/fmult.sv
// Signed fixed-point multiplier: full product, floor shift by FRAC, saturate.
module fmult
  import lms_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p,
  output logic             o_ovr
);

  logic signed [2*WIDTH-1:0] full;
  logic signed [63:0]        wide;
  logic signed [63:0]        shifted;
  logic signed [63:0]        narrowed;

  assign full = $signed(i_a) * $signed(i_b);
  assign wide = {{(64 - 2*WIDTH){full[2*WIDTH-1]}}, full};

  // Narrow the product; flag whenever clamping changed the shifted value.
  always_comb begin
    shifted  = wide >>> FRAC;
    narrowed = sat_trunc(wide, FRAC, WIDTH);
    o_ovr    = (narrowed != shifted);
    o_p      = narrowed[WIDTH-1:0];
  end

endmodule

// File: rtl/fsat_add.sv
// WIDTH-wide two's-complement adder that clamps on overflow.
module fsat_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovr
);

  logic [WIDTH:0] ext;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    ext   = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
    o_ovr = ext[WIDTH] ^ ext[WIDTH-1];
    if (!o_ovr) begin
      o_sum = ext[WIDTH-1:0];
    end else if (ext[WIDTH]) begin
      o_sum = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      o_sum = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/lms_coeff_update.sv
// Serial LMS coefficient engine: one multiplier walks the taps, results land
// in a shadow bank, and the whole vector is committed in a single cycle.
module lms_coeff_update
  import lms_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int TAPS  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_clear,
  input  logic [TAPS-1:0][WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0]           i_err,
  input  logic [WIDTH-1:0]           i_mu,
  output logic [TAPS-1:0][WIDTH-1:0] o_coeffs,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_ovr
);

  localparam int KW = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  state_t                     state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic [TAPS-1:0][WIDTH-1:0] x_q;
  logic [WIDTH-1:0]           err_q, mu_q, step_q;
  logic [TAPS-1:0][WIDTH-1:0] shadow_q;
  logic [TAPS-1:0][WIDTH-1:0] coeffs_q;
  logic                       done_q, ovr_q;

  logic [WIDTH-1:0] mul_a, mul_b, mul_p, sum;
  logic             mul_ovr, add_ovr;
  logic             accept, do_clear;

  assign do_clear = (state_q == IDLE) && i_clear;
  assign accept   = (state_q == IDLE) && !i_clear && i_start;

  // Single multiplier: mu*e while scaling, step*x[k] while updating.
  always_comb begin
    mul_a = step_q;
    mul_b = x_q[k_q];
    if (state_q == SCALE) begin
      mul_a = mu_q;
      mul_b = err_q;
    end
  end

  fmult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mult (
    .i_a   (mul_a),
    .i_b   (mul_b),
    .o_p   (mul_p),
    .o_ovr (mul_ovr)
  );

  fsat_add #(.WIDTH(WIDTH)) u_add (
    .i_a   (shadow_q[k_q]),
    .i_b   (mul_p),
    .o_sum (sum),
    .o_ovr (add_ovr)
  );

  // Next-state and tap-index sequencing.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE:   if (accept) state_d = SCALE;
      SCALE:  begin
        state_d = UPDATE;
        k_d     = '0;
      end
      UPDATE: begin
        if (k_q == K_LAST) begin
          state_d = COMMIT;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control, latched operands, step, commit and the sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      x_q      <= '0;
      err_q    <= '0;
      mu_q     <= '0;
      step_q   <= '0;
      coeffs_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= (state_q == COMMIT);
      if (accept) begin
        x_q   <= i_x;
        err_q <= i_err;
        mu_q  <= i_mu;
      end
      if (state_q == SCALE) step_q <= mul_p;
      if (do_clear) begin
        coeffs_q <= '0;
      end else if (state_q == COMMIT) begin
        coeffs_q <= shadow_q;
      end
      if (accept || do_clear) begin
        ovr_q <= 1'b0;
      end else if ((state_q == SCALE && mul_ovr) ||
                   (state_q == UPDATE && (mul_ovr || add_ovr))) begin
        ovr_q <= 1'b1;
      end
    end
  end

  // Shadow bank: each tap register loads only on its own UPDATE slot.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_shadow
      always_ff @(posedge i_clk) begin
        if (i_rst || do_clear) begin
          shadow_q[gi] <= '0;
        end else if (state_q == UPDATE && k_q == KW'(gi)) begin
          shadow_q[gi] <= sum;
        end
      end
    end
  endgenerate

  assign o_coeffs = coeffs_q;
  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;
  assign o_ovr    = ovr_q;

endmodule

// File: tb/tb_lms_coeff_update.sv
// Randomized and directed bench for lms_coeff_update against a plain-arithmetic model.
module tb_lms_coeff_update;

  localparam int WIDTH = 16;
  localparam int FRAC  = 14;
  localparam int TAPS  = 4;

  logic                       clk = 1'b0;
  logic                       i_rst, i_start, i_clear;
  logic [TAPS-1:0][WIDTH-1:0] i_x;
  logic [WIDTH-1:0]           i_err, i_mu;
  logic [TAPS-1:0][WIDTH-1:0] o_coeffs;
  logic                       o_busy, o_done, o_ovr;

  int checks = 0;
  int errors = 0;

  // Reference state: committed coefficients and overflow flag.
  int m_w [TAPS];
  bit m_ovr;
  int xs  [TAPS];
  int mu_v, err_v;

  always #5 clk = ~clk;

  lms_coeff_update #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_clear  (i_clear),
    .i_x      (i_x),
    .i_err    (i_err),
    .i_mu     (i_mu),
    .o_coeffs (o_coeffs),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ovr    (o_ovr)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd16();
    int v;
    v = int'($urandom_range(65535));
    return v - 32768;
  endfunction

  function automatic int clamp(input longint v, inout bit ovr);
    if (v > 32767)  begin ovr = 1'b1; return 32767;  end
    if (v < -32768) begin ovr = 1'b1; return -32768; end
    return int'(v);
  endfunction

  // Q2.14 product: exact product, floor division by 2^14, clamp.
  function automatic int qmul(input int a, input int b, inout bit ovr);
    longint p;
    p = (longint'(a) * longint'(b)) >>> FRAC;
    return clamp(p, ovr);
  endfunction

  function automatic logic [TAPS-1:0][WIDTH-1:0] pack(input int a0, input int a1,
                                                      input int a2, input int a3);
    logic [TAPS-1:0][WIDTH-1:0] v;
    v[0] = 16'(a0); v[1] = 16'(a1); v[2] = 16'(a2); v[3] = 16'(a3);
    return v;
  endfunction

  function automatic logic [TAPS-1:0][WIDTH-1:0] model_vec();
    return pack(m_w[0], m_w[1], m_w[2], m_w[3]);
  endfunction

  task automatic idle(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_done) dones++;
    end
  endtask

  // Called at a negedge; drives a start with mu_v/err_v/xs and returns at the
  // negedge of the o_done cycle. poke pulses i_start while busy.
  task automatic run_pass(input bit poke);
    logic [TAPS-1:0][WIDTH-1:0] old_vec;
    int  step;
    int  n;
    bit  seen;
    old_vec = model_vec();
    m_ovr = 1'b0;
    step = qmul(mu_v, err_v, m_ovr);
    for (int k = 0; k < TAPS; k++) begin
      int p;
      p = qmul(step, xs[k], m_ovr);
      m_w[k] = clamp(longint'(m_w[k]) + longint'(p), m_ovr);
    end

    i_start = 1'b1;
    i_mu    = 16'(mu_v);
    i_err   = 16'(err_v);
    for (int k = 0; k < TAPS; k++) i_x[k] = 16'(xs[k]);
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    i_mu    = 16'($urandom);
    i_err   = 16'($urandom);
    for (int k = 0; k < TAPS; k++) i_x[k] = 16'($urandom);
    check("busy_after_start", longint'(o_busy), 1);
    check("ovr_cleared_on_start", longint'(o_ovr), 0);

    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (o_done) begin
        seen = 1'b1;
      end else begin
        check("coeffs_hold_busy", longint'(o_coeffs), longint'(old_vec));
        if (poke && n == 2) i_start = 1'b1;
        if (poke && n == 3) i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    check("done_seen", longint'(seen), 1);
    check("done_latency", n, TAPS + 2);
    check("busy_in_done", longint'(o_busy), 0);
    check("coeffs", longint'(o_coeffs), longint'(model_vec()));
    check("ovr", longint'(o_ovr), longint'(m_ovr));
    $display("pass mu=%0d err=%0d x=%0d,%0d,%0d,%0d -> w=%0d,%0d,%0d,%0d ovr=%0d",
             mu_v, err_v, xs[0], xs[1], xs[2], xs[3],
             m_w[0], m_w[1], m_w[2], m_w[3], m_ovr);
  endtask

  initial begin
    int d;
    i_rst = 1'b1; i_start = 1'b0; i_clear = 1'b0;
    i_x = '0; i_err = '0; i_mu = '0;
    for (int k = 0; k < TAPS; k++) m_w[k] = 0;
    m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;

    // Reset state after idling.
    idle(10, d);
    check("rst_coeffs", longint'(o_coeffs), 0);
    check("rst_busy", longint'(o_busy), 0);
    check("rst_done", d, 0);
    check("rst_ovr", longint'(o_ovr), 0);
    $display("reset idle done");

    // Directed pass, then a back-to-back repeat started in the done cycle.
    mu_v = 8192; err_v = 8192;
    xs[0] = 4096; xs[1] = -4096; xs[2] = 8192; xs[3] = 0;
    run_pass(1'b0);
    check("dir1_coeffs", longint'(o_coeffs), longint'(pack(1024, -1024, 2048, 0)));
    run_pass(1'b0);
    check("dir2_coeffs", longint'(o_coeffs), longint'(pack(2048, -2048, 4096, 0)));
    idle(1, d);
    check("done_single_pulse", d, 0);

    // Clear, then two saturating passes.
    i_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_clear = 1'b0;
    for (int k = 0; k < TAPS; k++) m_w[k] = 0;
    check("clear_coeffs", longint'(o_coeffs), 0);
    $display("clear");
    mu_v = 32767; err_v = 16384;
    xs[0] = 16384; xs[1] = 0; xs[2] = 0; xs[3] = 0;
    run_pass(1'b0);
    check("sat1_w0", longint'($signed(o_coeffs[0])), 32767);
    check("sat1_ovr", longint'(o_ovr), 0);
    idle(2, d);
    run_pass(1'b0);
    check("sat2_w0", longint'($signed(o_coeffs[0])), 32767);
    check("sat2_ovr", longint'(o_ovr), 1);
    idle(3, d);
    check("ovr_sticky", longint'(o_ovr), 1);
    mu_v = 100; err_v = 100;
    for (int k = 0; k < TAPS; k++) xs[k] = int'($urandom_range(2000)) - 1000;
    run_pass(1'b0);

    // Start pulse while busy is dropped.
    idle(1, d);
    mu_v = rnd16(); err_v = rnd16();
    for (int k = 0; k < TAPS; k++) xs[k] = rnd16();
    run_pass(1'b1);
    idle(10, d);
    check("poke_no_extra_done", d, 0);
    check("poke_idle_busy", longint'(o_busy), 0);

    // Clear and start together: clear wins, no pass.
    i_clear = 1'b1; i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_clear = 1'b0; i_start = 1'b0;
    for (int k = 0; k < TAPS; k++) m_w[k] = 0;
    m_ovr = 1'b0;
    check("clrstart_busy", longint'(o_busy), 0);
    check("clrstart_coeffs", longint'(o_coeffs), 0);
    check("clrstart_ovr", longint'(o_ovr), 0);
    idle(8, d);
    check("clrstart_no_done", d, 0);
    $display("clear+start");

    // Give the coefficients a nonzero value, then reset mid-pass.
    mu_v = 8192; err_v = 8192;
    xs[0] = 4096; xs[1] = -4096; xs[2] = 8192; xs[3] = 1000;
    run_pass(1'b0);
    idle(1, d);
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_coeffs", longint'(o_coeffs), 0);
    check("rstmid_busy", longint'(o_busy), 0);
    check("rstmid_done", longint'(o_done), 0);
    check("rstmid_ovr", longint'(o_ovr), 0);
    i_rst = 1'b0;
    for (int k = 0; k < TAPS; k++) m_w[k] = 0;
    m_ovr = 1'b0;
    idle(10, d);
    check("rstmid_no_done", d, 0);
    $display("reset mid-pass");
    run_pass(1'b0);

    // Random passes, alternating back-to-back and gapped starts.
    for (int t = 0; t < 20; t++) begin
      if (t % 3 == 0) begin
        mu_v = rnd16(); err_v = rnd16();
        for (int k = 0; k < TAPS; k++) xs[k] = rnd16();
      end else begin
        mu_v = int'($urandom_range(8000)) - 4000;
        err_v = int'($urandom_range(16000)) - 8000;
        for (int k = 0; k < TAPS; k++) xs[k] = int'($urandom_range(32000)) - 16000;
      end
      if (t % 2 == 1) idle(int'($urandom_range(3)) + 1, d);
      run_pass(1'b0);
    end
    idle(2, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
